shadow_dump_ctrl: RTL and testbench

//  Sequencer for one shadow_capture instance: keeps capture running while armed, freezes it POST_TRIG cycles after a trigger,

---
 rtl/shadow_dump_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_shadow_dump_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_dump_ctrl.sv
// shadow_dump_ctrl: sequencer for one shadow_capture instance.
// It keeps capture running while armed and freezes it POST_TRIG cycles after a trigger.
// It then dumps chains 0..CHAINS-1 one at a time through a one-hot dump_en.
// Chain bits are queued in a 4-entry FIFO and presented on a valid/ready host port.
// Optional feature macro: SHADOW_DUMP_SKIP_EN adds skip_mask to bypass selected chains.
module shadow_dump_ctrl #(
  parameter int unsigned CHAINS    = 64,
  parameter int unsigned POST_TRIG = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
`ifdef SHADOW_DUMP_SKIP_EN
  input  logic [CHAINS-1:0] skip_mask,
`endif
  output logic              capture_en,
  output logic [CHAINS-1:0] dump_en,
  input  logic [CHAINS-1:0] chains_out,
  input  logic [CHAINS-1:0] chains_out_vld,
  input  logic [CHAINS-1:0] chains_out_done,
  output logic              dout,
  output logic [5:0]        dout_chain,
  output logic              dout_sof,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              busy,
  output logic              dump_done,
  output logic              err_timeout
);

  localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StArmed, StPost, StFreeze, StDump, StNext, StDrain
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [7:0]         post_q, post_d;
  logic [ToW-1:0]     to_q, to_d;
  logic               sof_q, sof_d;
  logic               err_q, err_d;
  logic [CHAINS-1:0]  skip_q, skip_d;
  logic [CHAINS-1:0]  skip_in;

  // FIFO entry: {data bit, chain index, sof}
  logic [7:0]         mem_q [4];
  logic [7:0]         mem_d [4];
  logic [1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [2:0]         cnt_q, cnt_d;

  logic [CHAINS-1:0]  sel, sel_nxt;
  logic               sel_bit, sel_vld, sel_done;
  logic               gate_open, push, pop, last_chain;
  logic [7:0]         head;

`ifdef SHADOW_DUMP_SKIP_EN
  assign skip_in = skip_mask;
`else
  assign skip_in = '0;
`endif

  // Decode current and following chain index into one-hot selects
  always_comb begin
    sel     = '0;
    sel_nxt = '0;
    for (int i = 0; i < CHAINS; i++) begin
      sel[i]     = (idx_q == 6'(i));
      sel_nxt[i] = ((idx_q + 6'd1) == 6'(i));
    end
  end

  assign sel_bit    = |(chains_out & sel);
  assign sel_vld    = |(chains_out_vld & sel);
  assign sel_done   = |(chains_out_done & sel);
  assign last_chain = (idx_q == 6'(CHAINS - 1));

  // Two free slots leave room for the bit already in flight from the chain
  assign gate_open  = (cnt_q <= 3'd2);
  assign push       = (state_q == StDump) && sel_vld;
  assign dout_vld   = (cnt_q != 3'd0);
  assign pop        = dout_vld && dout_rdy;

  // Next-state logic for the sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    post_d  = post_q;
    to_d    = to_q;
    sof_d   = sof_q;
    err_d   = err_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StArmed;
      end
      StArmed: begin
        if (trig) begin
          err_d   = 1'b0;
          post_d  = '0;
          state_d = (POST_TRIG == 0) ? StFreeze : StPost;
        end else if (!arm) begin
          state_d = StIdle;
        end
      end
      StPost: begin
        if (post_q == 8'(POST_TRIG - 1)) state_d = StFreeze;
        else                              post_d  = post_q + 8'd1;
      end
      StFreeze: begin
        idx_d   = '0;
        skip_d  = skip_in;
        sof_d   = 1'b1;
        to_d    = '0;
        state_d = skip_in[0] ? StNext : StDump;
      end
      StDump: begin
        if (push) sof_d = 1'b0;
        if (sel_done) begin
          state_d = StNext;
        end else if (sel_vld) begin
          to_d = '0;
        end else if (gate_open) begin
          if (to_q == ToW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StNext;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      StNext: begin
        sof_d = 1'b1;
        to_d  = '0;
        if (last_chain) begin
          state_d = StDrain;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = (|(skip_q & sel_nxt)) ? StNext : StDump;
        end
      end
      StDrain: begin
        if (cnt_q == 3'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer/occupancy update; push and pop may coincide at any level
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    if (push) begin
      mem_d[wr_q] = {sel_bit, idx_q, sof_q};
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
  end

  // State and FIFO registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      post_q  <= '0;
      to_q    <= '0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
      skip_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      post_q  <= post_d;
      to_q    <= to_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Output decode; host fields read as zero whenever the FIFO is empty
  always_comb begin
    head        = mem_q[rd_q];
    capture_en  = (state_q == StArmed) || (state_q == StPost);
    dump_en     = ((state_q == StDump) && gate_open) ? sel : '0;
    dout        = dout_vld & head[7];
    dout_chain  = dout_vld ? head[6:1] : 6'd0;
    dout_sof    = dout_vld & head[0];
    busy        = !((state_q == StIdle) || (state_q == StArmed));
    dump_done   = (state_q == StDrain) && (cnt_q == 3'd0);
    err_timeout = err_q;
  end

  // Free-slot gating guarantees a push never lands on a full FIFO
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (cnt_q == 3'd4)));

endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Scoreboard bench for shadow_dump_ctrl with CHAINS=4, POST_TRIG=8, TIMEOUT=16.
// A behavioural chain model answers dump_en one cycle later; expected beats are
// queued by the stimulus and checked by an independent output monitor.
module tb_shadow_dump_ctrl;
  localparam int unsigned CHAINS = 4;

  logic              clk = 1'b0;
  logic              rst, arm, trig, dout_rdy;
  logic              capture_en, dout, dout_sof, dout_vld, busy, dump_done, err_timeout;
  logic [CHAINS-1:0] dump_en, chains_out, chains_out_vld, chains_out_done;
  logic [5:0]        dout_chain;
`ifdef SHADOW_DUMP_SKIP_EN
  logic [CHAINS-1:0] skip_mask;
`endif

  shadow_dump_ctrl #(.CHAINS(CHAINS), .POST_TRIG(8), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .trig            (trig),
`ifdef SHADOW_DUMP_SKIP_EN
    .skip_mask       (skip_mask),
`endif
    .capture_en      (capture_en),
    .dump_en         (dump_en),
    .chains_out      (chains_out),
    .chains_out_vld  (chains_out_vld),
    .chains_out_done (chains_out_done),
    .dout            (dout),
    .dout_chain      (dout_chain),
    .dout_sof        (dout_sof),
    .dout_vld        (dout_vld),
    .dout_rdy        (dout_rdy),
    .busy            (busy),
    .dump_done       (dump_done),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q [$];
  logic [7:0] pat [CHAINS];
  int         chain_len;
  logic [CHAINS-1:0] mute;
  int         sent [CHAINS];
  int         occ, max_occ, gate_viol, done_pulses, en2_cycles;
  logic [CHAINS-1:0] en_seen;

  task automatic check(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Chain model: one-cycle latency from dump_en to vld, done with the last bit
  always @(posedge clk) begin
    for (int c = 0; c < CHAINS; c++) begin
      if (rst) begin
        sent[c]            <= 0;
        chains_out_vld[c]  <= 1'b0;
        chains_out_done[c] <= 1'b0;
        chains_out[c]      <= 1'b0;
      end else if (dump_en[c] && !mute[c] && sent[c] < chain_len) begin
        chains_out_vld[c]  <= 1'b1;
        chains_out[c]      <= pat[c][sent[c]];
        chains_out_done[c] <= (sent[c] == chain_len - 1);
        sent[c]            <= sent[c] + 1;
      end else begin
        chains_out_vld[c]  <= 1'b0;
        chains_out_done[c] <= 1'b0;
        chains_out[c]      <= 1'b0;
      end
    end
  end

  // Bench-side FIFO occupancy: every model vld is a push, every handshake a pop
  always @(posedge clk) begin
    if (rst) occ <= 0;
    else occ <= occ + ((|chains_out_vld) ? 1 : 0) - ((dout_vld && dout_rdy) ? 1 : 0);
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (dump_en != '0 && occ >= 3) gate_viol++;
      if (occ > max_occ) max_occ = occ;
      if (dump_done) done_pulses++;
      if (dump_en[2]) en2_cycles++;
      en_seen = en_seen | dump_en;
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {dout, dout_chain, dout_sof}, 'hfff);
        end else begin
          check("beat", {dout, dout_chain, dout_sof}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    max_occ = 0; gate_viol = 0; done_pulses = 0; en2_cycles = 0; en_seen = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; trig = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic expect_chains(input logic [CHAINS-1:0] absent);
    for (int c = 0; c < CHAINS; c++)
      if (!absent[c])
        for (int k = 0; k < chain_len; k++)
          exp_q.push_back({pat[c][k], 6'(c), (k == 0)});
  endtask

  task automatic start(input bit timing);
    arm = 1'b1;
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0; arm = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (timing && k == 8)  check("capture_en_post", int'(capture_en), 1);
      if (timing && k == 9)  check("capture_en_freeze", int'(capture_en), 0);
      if (timing && k == 10) check("dump_en_chain0", int'(dump_en), 1);
      if (k < 10) @(negedge clk);
    end
  endtask

  task automatic finish_dump(input string tag);
    int n = 0;
    while (done_pulses == 0 && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, int'(done_pulses != 0), 1);
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, done_pulses, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_not_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pat[0] = 8'b0001_0101; pat[1] = 8'b0000_1010;
    pat[2] = 8'b0001_0110; pat[3] = 8'b0000_1011;
    chain_len = 3; mute = '0; dout_rdy = 1'b1;
`ifdef SHADOW_DUMP_SKIP_EN
    skip_mask = '0;
`endif
    do_reset();
    check("reset_outputs",
          {capture_en, dump_en, dout_vld, dout, dout_chain, dout_sof, busy, dump_done, err_timeout},
          0);

    // Timing after trig, then a full 4x3-bit dump with the host always ready
    expect_chains('0);
    start(1'b1);
    finish_dump("basic");
    check("basic_no_err", int'(err_timeout), 0);

    // Host stalls: FIFO fills, dump_en is gated, stream continues intact afterwards
    do_reset();
    chain_len = 5; dout_rdy = 1'b0;
    expect_chains('0);
    start(1'b0);
    repeat (20) @(negedge clk);
    check("stall_max_occ", max_occ, 4);
    check("stall_dout_vld", int'(dout_vld), 1);
    dout_rdy = 1'b1;
    finish_dump("stall");
    check("stall_gating", gate_viol, 0);

    // Chain 2 silent: 16 open cycles then abandoned, chain 3 still dumped
    do_reset();
    chain_len = 3; mute = 4'b0100;
    expect_chains(4'b0100);
    start(1'b0);
    finish_dump("timeout");
    check("timeout_open_cycles", en2_cycles, 16);
    check("timeout_err", int'(err_timeout), 1);
    repeat (3) @(negedge clk);
    check("timeout_sticky", int'(err_timeout), 1);
    arm = 1'b1;
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0; arm = 1'b0;
    check("timeout_cleared_by_trig", int'(err_timeout), 0);
    mute = '0;

    // Reset in the middle of a dump with two entries queued, then re-arm
    do_reset();
    chain_len = 5; dout_rdy = 1'b0;
    start(1'b0);
    begin
      int n = 0;
      while (occ != 2 && n < 100) begin @(negedge clk); n++; end
      check("midreset_reached_2", occ, 2);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          {capture_en, dump_en, dout_vld, dout, dout_chain, dout_sof, busy, dump_done, err_timeout},
          0);
    rst = 1'b0;
    clear_stats();
    chain_len = 3; dout_rdy = 1'b1;
    expect_chains('0);
    start(1'b0);
    finish_dump("rearm");

`ifdef SHADOW_DUMP_SKIP_EN
    // Skip chains 0 and 2
    do_reset();
    skip_mask = 4'b0101;
    expect_chains(4'b0101);
    start(1'b0);
    finish_dump("skip");
    check("skip_no_dump_en", int'(en_seen & 4'b0101), 0);
    skip_mask = '0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
